par8_slave: RTL

FPGA-side endpoint of the 8-bit parallel bus driven by the Raspberry Pi master (bus_clk, bus_data, bus_rnw). It aligns to the master's two-word sync preamble, then turns master write strobes into single-cycle received-byte pulses for the command parser, and serves read strobes from a one-byte transmit holding register. It sits between the top-level bus pins (tristate buffer in the top) and the command parser.

---
 rtl/par8_slave.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/par8_slave.sv
// rtl/par8_slave.sv - Raspberry Pi 8-bit parallel bus endpoint: preamble alignment, write capture, read holding register
// Build option: define PAR8_TIMEOUT_EN to drop sync when bus_clk stays low for TIMEOUT_CYCLES.
module par8_slave #(
  parameter logic [7:0] SYNC_WORD0     = 8'hB8,
  parameter logic [7:0] SYNC_WORD1     = 8'h8B,
  parameter int         STABLE_CYCLES  = 2,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bus_clk,
  input  logic       bus_rnw,
  input  logic [7:0] bus_data_in,
  output logic [7:0] bus_data_out,
  output logic       bus_oe,
  output logic       synced,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_underrun,
  output logic       sync_lost
);

  typedef enum logic [1:0] {HUNT0, HUNT1, SYNCED} state_t;

  localparam logic [3:0] STABLE_LAST = 4'(STABLE_CYCLES);

  state_t     state_q, state_d;
  logic [3:0] stable_q, stable_d;
  logic       clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d, clk_s3_q, clk_s3_d;
  logic       rnw_s1_q, rnw_s1_d, rnw_s2_q, rnw_s2_d;
  logic [7:0] data_s1_q, data_s1_d, data_s2_q, data_s2_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic [7:0] dout_q, dout_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       underrun_q, underrun_d;
  logic       bus_rise, bus_fall;

  // Edges come from the second and third bus_clk stages; data/rnw use the second stage.
  assign bus_rise = clk_s2_q & ~clk_s3_q;
  assign bus_fall = ~clk_s2_q & clk_s3_q;

`ifdef PAR8_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d, to_next;
  logic            sync_lost_q, sync_lost_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d     = state_q;
    stable_d    = stable_q;
    clk_s1_d    = bus_clk;
    clk_s2_d    = clk_s1_q;
    clk_s3_d    = clk_s2_q;
    rnw_s1_d    = bus_rnw;
    rnw_s2_d    = rnw_s1_q;
    data_s1_d   = bus_data_in;
    data_s2_d   = data_s1_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    dout_d      = dout_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;

    case (state_q)
      HUNT0: begin
        if (clk_s2_q && data_s2_q == SYNC_WORD0) begin
          if (stable_q + 4'd1 == STABLE_LAST) begin
            state_d  = HUNT1;
            stable_d = '0;
          end else begin
            stable_d = stable_q + 4'd1;
          end
        end else begin
          stable_d = '0;
        end
      end
      HUNT1: begin
        if (data_s2_q == SYNC_WORD1) begin
          if (stable_q + 4'd1 == STABLE_LAST) begin
            state_d  = SYNCED;
            stable_d = '0;
          end else begin
            stable_d = stable_q + 4'd1;
          end
        end else if (data_s2_q == SYNC_WORD0) begin
          stable_d = '0;
        end else begin
          state_d  = HUNT0;
          stable_d = '0;
        end
      end
      SYNCED: begin
        if (bus_rise && !rnw_s2_q) begin
          rx_data_d  = data_s2_q;
          rx_valid_d = 1'b1;
        end
        if (bus_fall && rnw_s2_q) begin
          if (hold_full_q) begin
            dout_d      = hold_q;
            hold_full_d = 1'b0;
          end else begin
            dout_d     = 8'h00;
            underrun_d = 1'b1;
          end
        end
      end
      default: begin
        state_d  = HUNT0;
        stable_d = '0;
      end
    endcase

    // A load accepted on the same cycle as an empty-register read lands for the next read.
    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

`ifdef PAR8_TIMEOUT_EN
    to_cnt_d    = '0;
    sync_lost_d = 1'b0;
    to_next     = to_cnt_q + TO_W'(1);
    if (state_q == SYNCED && !clk_s2_q) begin
      if (to_next == TO_LAST) begin
        state_d     = HUNT0;
        stable_d    = '0;
        hold_full_d = 1'b0;
        sync_lost_d = 1'b1;
      end else begin
        to_cnt_d = to_next;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= HUNT0;
      stable_q    <= '0;
      clk_s1_q    <= 1'b0;
      clk_s2_q    <= 1'b0;
      clk_s3_q    <= 1'b0;
      rnw_s1_q    <= 1'b0;
      rnw_s2_q    <= 1'b0;
      data_s1_q   <= '0;
      data_s2_q   <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      dout_q      <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
`ifdef PAR8_TIMEOUT_EN
      to_cnt_q    <= '0;
      sync_lost_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      stable_q    <= stable_d;
      clk_s1_q    <= clk_s1_d;
      clk_s2_q    <= clk_s2_d;
      clk_s3_q    <= clk_s3_d;
      rnw_s1_q    <= rnw_s1_d;
      rnw_s2_q    <= rnw_s2_d;
      data_s1_q   <= data_s1_d;
      data_s2_q   <= data_s2_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      dout_q      <= dout_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
`ifdef PAR8_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
      sync_lost_q <= sync_lost_d;
`endif
    end
  end

  assign synced       = (state_q == SYNCED);
  assign bus_oe       = synced && rnw_s2_q;
  assign bus_data_out = dout_q;
  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign tx_ready     = !hold_full_q;
  assign tx_underrun  = underrun_q;
`ifdef PAR8_TIMEOUT_EN
  assign sync_lost    = sync_lost_q;
`else
  assign sync_lost    = 1'b0;
`endif

endmodule
